// File: rtl/dig_scan_pkg.sv
// Shared types and constants for the 8-digit display scan controller.
// Optional macro DIG_SCAN_LZ_SUPPRESS_EN enables the leading-zero suppression helper.
package dig_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam int NUM_DIGITS = 8;
  localparam int SEL_W      = 3;
  localparam int DIGIT_W    = 4;

`ifdef DIG_SCAN_LZ_SUPPRESS_EN
  // Clears mask bits of zero digits above the most significant nonzero one; digit 0 always kept.
  function automatic logic [NUM_DIGITS-1:0] lz_suppress(
    input logic [NUM_DIGITS*DIGIT_W-1:0] d,
    input logic [NUM_DIGITS-1:0]         m
  );
    logic [NUM_DIGITS-1:0] r;
    logic                  seen;
    r    = m;
    seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (d[k*DIGIT_W +: DIGIT_W] != {DIGIT_W{1'b0}}) begin
        seen = 1'b1;
      end else begin
        seen = seen;
      end
      if (!seen) begin
        r[k] = 1'b0;
      end else begin
        r[k] = r[k];
      end
    end
    return r;
  endfunction
`endif

endpackage

// File: rtl/dig_scan_ctrl_tick_gen.sv
// Prescaler producing a one-cycle tick every DIV clocks; held at zero while clr is high.
module tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_last_s;

  assign at_last_s = (cnt_q == LAST);
  assign tick      = at_last_s && !clr;

  // Next count: wrap at DIV-1, forced to zero while cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || at_last_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dig_scan_ctrl.sv
// Multiplexed 8-digit scan controller: drives dec3to8 sel/en with blanking gaps and frame-coherent digit data.
// Define DIG_SCAN_LZ_SUPPRESS_EN to blank leading zero digits (computed at each shadow load).
module dig_scan_ctrl
  import dig_scan_pkg::*;
#(
  parameter int DIV         = 50000,
  parameter int BLANK_TICKS = 1,
  parameter int SHOW_TICKS  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  input  logic [NUM_DIGITS-1:0]         digit_mask,
  output logic [SEL_W-1:0]              sel,
  output logic                          en,
  output logic [DIGIT_W-1:0]            digit,
  output logic                          frame_done
);

  localparam int MAX_TICKS = (BLANK_TICKS > SHOW_TICKS) ? BLANK_TICKS : SHOW_TICKS;
  localparam int TCW       = $clog2(MAX_TICKS + 1);

  localparam logic [TCW-1:0]   BLANK_LAST = TCW'(BLANK_TICKS - 1);
  localparam logic [TCW-1:0]   SHOW_LAST  = TCW'(SHOW_TICKS - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_DIGITS - 1);

  scan_state_t                   state_q, state_d;
  logic [SEL_W-1:0]              sel_q, sel_d;
  logic                          en_q, en_d;
  logic [DIGIT_W-1:0]            digit_q, digit_d;
  logic                          frame_done_q, frame_done_d;
  logic [TCW-1:0]                tcnt_q, tcnt_d;
  logic [NUM_DIGITS*DIGIT_W-1:0] shd_digits_q, shd_digits_d;
  logic [NUM_DIGITS-1:0]         shd_mask_q, shd_mask_d;
  logic [NUM_DIGITS-1:0]         eff_mask_s;
  logic                          load_s;
  logic                          tick_s;
  logic                          clr_s;

`ifdef DIG_SCAN_LZ_SUPPRESS_EN
  assign eff_mask_s = lz_suppress(digits, digit_mask);
`else
  assign eff_mask_s = digit_mask;
`endif

  assign clr_s = (state_q == IDLE);

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .tick (tick_s)
  );

  // Scan FSM, tick counter, shadow reload and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    tcnt_d       = tcnt_q;
    frame_done_d = 1'b0;
    load_s       = 1'b0;
    shd_digits_d = shd_digits_q;
    shd_mask_d   = shd_mask_q;

    if (!run) begin
      state_d = IDLE;
      sel_d   = '0;
      tcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          sel_d   = '0;
          tcnt_d  = '0;
          load_s  = 1'b1;
        end
        BLANK: begin
          if (tick_s && (tcnt_q == BLANK_LAST)) begin
            state_d = SHOW;
            tcnt_d  = '0;
          end else if (tick_s) begin
            tcnt_d = tcnt_q + TCW'(1);
          end else begin
            tcnt_d = tcnt_q;
          end
        end
        SHOW: begin
          if (tick_s && (tcnt_q == SHOW_LAST)) begin
            // Frame wrap reloads the shadows in the same cycle sel returns to 0.
            state_d      = BLANK;
            tcnt_d       = '0;
            sel_d        = sel_q + SEL_W'(1);
            frame_done_d = (sel_q == SEL_LAST);
            load_s       = (sel_q == SEL_LAST);
          end else if (tick_s) begin
            tcnt_d = tcnt_q + TCW'(1);
          end else begin
            tcnt_d = tcnt_q;
          end
        end
        default: begin
          state_d = IDLE;
          sel_d   = '0;
          tcnt_d  = '0;
        end
      endcase
    end

    if (load_s) begin
      shd_digits_d = digits;
      shd_mask_d   = eff_mask_s;
    end else begin
      shd_digits_d = shd_digits_q;
      shd_mask_d   = shd_mask_q;
    end

    en_d = (state_d == SHOW) && shd_mask_d[sel_d];
    if (state_d == IDLE) begin
      digit_d = '0;
    end else begin
      digit_d = shd_digits_d[sel_d*DIGIT_W +: DIGIT_W];
    end
  end

  // State, counter, shadow and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      en_q         <= 1'b0;
      digit_q      <= '0;
      frame_done_q <= 1'b0;
      tcnt_q       <= '0;
      shd_digits_q <= '0;
      shd_mask_q   <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      en_q         <= en_d;
      digit_q      <= digit_d;
      frame_done_q <= frame_done_d;
      tcnt_q       <= tcnt_d;
      shd_digits_q <= shd_digits_d;
      shd_mask_q   <= shd_mask_d;
    end
  end

  assign sel        = sel_q;
  assign en         = en_q;
  assign digit      = digit_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dig_scan_ctrl.sv
// Self-checking bench for dig_scan_ctrl with DIV=4, BLANK_TICKS=1, SHOW_TICKS=2 (12-cycle slot, 96-cycle frame).
module tb_dig_scan_ctrl;

  localparam int DIV       = 4;
  localparam int BT        = 1;
  localparam int ST        = 2;
  localparam int BLANK_CYC = BT * DIV;
  localparam int SLOT      = (BT + ST) * DIV;
  localparam int FRAME     = 8 * SLOT;

  logic        clk;
  logic        rst;
  logic        run;
  logic [31:0] digits;
  logic [7:0]  digit_mask;
  logic [2:0]  sel;
  logic        en;
  logic [3:0]  digit;
  logic        frame_done;
  logic [7:0]  dec_out;

  int n_checks = 0;
  int n_pass   = 0;

  dig_scan_ctrl #(
    .DIV         (DIV),
    .BLANK_TICKS (BT),
    .SHOW_TICKS  (ST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .digits     (digits),
    .digit_mask (digit_mask),
    .sel        (sel),
    .en         (en),
    .digit      (digit),
    .frame_done (frame_done)
  );

  // Stand-in for the downstream dec3to8.
  assign dec_out = en ? (8'h01 << sel) : 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Effective mask: everything above the highest nonzero digit (digit 0 excluded) is blanked.
  function automatic logic [7:0] model_mask(input logic [31:0] d, input logic [7:0] m);
    logic [7:0] r;
    r = m;
`ifdef DIG_SCAN_LZ_SUPPRESS_EN
    begin
      int top;
      top = 0;
      for (int k = 1; k < 8; k++) begin
        if (((d >> (4 * k)) & 32'hF) != 32'h0) top = k;
      end
      for (int k = 1; k < 8; k++) begin
        if (k > top) r[k] = 1'b0;
      end
    end
`endif
    return r;
  endfunction

  // Model: cycles since first BLANK cycle plus the data latched for the current frame.
  logic        m_act;
  int          m_n;
  logic [31:0] m_dig;
  logic [7:0]  m_msk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 1'b0;
      m_n   <= 0;
      m_dig <= 32'h0;
      m_msk <= 8'h0;
    end else if (!run) begin
      m_act <= 1'b0;
      m_n   <= 0;
    end else if (!m_act) begin
      m_act <= 1'b1;
      m_n   <= 0;
      m_dig <= digits;
      m_msk <= model_mask(digits, digit_mask);
    end else begin
      m_n <= m_n + 1;
      if ((m_n + 1) % FRAME == 0) begin
        m_dig <= digits;
        m_msk <= model_mask(digits, digit_mask);
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      int   e_sel;
      logic e_en;
      int   e_dig;
      logic e_fd;
      e_sel = m_act ? (m_n / SLOT) % 8 : 0;
      e_en  = m_act && ((m_n % SLOT) >= BLANK_CYC) && m_msk[e_sel];
      e_dig = m_act ? ((m_dig >> (4 * e_sel)) & 32'hF) : 0;
      e_fd  = m_act && (m_n > 0) && (m_n % FRAME == 0);
      chk("cyc_sel", {29'h0, sel}, e_sel);
      chk("cyc_en", {31'h0, en}, {31'h0, e_en});
      chk("cyc_digit", {28'h0, digit}, e_dig);
      chk("cyc_frame_done", {31'h0, frame_done}, {31'h0, e_fd});
      if (e_en) chk("cyc_dec", {24'h0, dec_out}, 32'h1 << e_sel);
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; run = 1'b0; digits = 32'h0; digit_mask = 8'h0;
    step(3);
    chk("rst_sel", {29'h0, sel}, 32'h0);
    chk("rst_en", {31'h0, en}, 32'h0);
    chk("rst_digit", {28'h0, digit}, 32'h0);
    rst = 1'b0;
    step(20);
    chk("idle_en", {31'h0, en}, 32'h0);
    chk("idle_fd", {31'h0, frame_done}, 32'h0);

    // Full frame
    digits = 32'h7654_3210; digit_mask = 8'hFF; run = 1'b1;
    step(1);
    chk("f_n0_en", {31'h0, en}, 32'h0);
    step(3);
    chk("f_n3_en", {31'h0, en}, 32'h0);
    step(1);
    chk("f_n4_en", {31'h0, en}, 32'h1);
    chk("f_n4_dec", {24'h0, dec_out}, 32'h01);
    step(36);
    chk("f_n40_sel", {29'h0, sel}, 32'h3);
    chk("f_n40_digit", {28'h0, digit}, 32'h3);
    chk("f_n40_dec", {24'h0, dec_out}, 32'h08);
    step(55);
    chk("f_n95_fd", {31'h0, frame_done}, 32'h0);
    step(1);
    chk("f_n96_fd", {31'h0, frame_done}, 32'h1);
    chk("f_n96_sel", {29'h0, sel}, 32'h0);
    step(1);
    chk("f_n97_fd", {31'h0, frame_done}, 32'h0);

    // Coherence: change digits during digit 3 of frame 2 (n=136)
    step(39);
    digits = 32'hFFFF_FFFF;
    step(24);
    chk("coh_d5", {28'h0, digit}, 32'h5);
    step(60);
    chk("coh_next_f", {28'h0, digit}, 32'hF);
    chk("coh_next_sel", {29'h0, sel}, 32'h2);

    // Mask 1010_0101 takes effect at frame 4 (n=288)
    digit_mask = 8'b1010_0101;
    step(68);
    cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (en) cnt++;
      step(1);
    end
    chk("mask_en_cycles", cnt, 32'd32);

    // Stop during SHOW of digit 5 (n=448)
    step(64);
    chk("stop_pre_en", {31'h0, en}, 32'h1);
    chk("stop_pre_sel", {29'h0, sel}, 32'h5);
    run = 1'b0;
    step(1);
    chk("stop_en", {31'h0, en}, 32'h0);
    chk("stop_sel", {29'h0, sel}, 32'h0);
    step(3);
    run = 1'b1;
    step(1);
    chk("restart_sel", {29'h0, sel}, 32'h0);
    step(4);
    chk("restart_en", {31'h0, en}, 32'h1);
    step(26);
    chk("pre_arst_en", {31'h0, en}, 32'h1);
    #1 rst = 1'b1;
    #1 chk("arst_en_async", {31'h0, en}, 32'h0);
    chk("arst_sel_async", {29'h0, sel}, 32'h0);
    #1 rst = 1'b0;
    step(1);
    chk("post_arst_sel", {29'h0, sel}, 32'h0);
    chk("post_arst_en", {31'h0, en}, 32'h0);

    // Leading-zero pattern
    run = 1'b0;
    step(2);
    digits = 32'h0001_0200; digit_mask = 8'hFF; run = 1'b1;
    step(1);
    cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (en) cnt++;
      step(1);
    end
`ifdef DIG_SCAN_LZ_SUPPRESS_EN
    chk("lz_en_cycles", cnt, 32'd40);
`else
    chk("lz_en_cycles", cnt, 32'd64);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dig_scan_ctrl.md
Name: dig_scan_ctrl

Overview:
- Upstream driver for the 3-to-8 digit decoder (dec3to8) in the multiplexed 8-digit display path.
- Steps a 3-bit digit select through 0..7 at a prescaled rate and drives the decoder's `en` and `in`.
- Inserts a blanking gap between digits (anti-ghosting) and presents the 4-bit value of the selected digit to the segment encoder.
- Latches the digit bus once per frame so a displayed frame is always coherent.

Parameters:
- DIV, 50000: clk cycles per scan tick; legal range >= 1.
- BLANK_TICKS, 1: ticks with `en`=0 before each digit is shown; legal range >= 1.
- SHOW_TICKS, 4: ticks with `en` asserted per digit; legal range >= 1.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- run  in  1  scan enable; low forces the idle state.
- digits  in  32  eight 4-bit digit values; digit k is `digits[4k+3:4k]`.
- digit_mask  in  8  per-digit display enable; sampled with `digits`.
- sel  out  3  digit select; drives decoder `in`.
- en  out  1  decoder enable; high only while showing an unmasked digit.
- digit  out  4  value of the currently selected digit.
- frame_done  out  1  one-cycle pulse when `sel` wraps from 7 to 0.

Behaviour:
- Reset (asynchronous, active-high): immediate, regardless of the current state.
  - state=IDLE; `sel`=0, `en`=0, `digit`=0, `frame_done`=0.
  - Prescaler = 0, tick counter = 0, shadow registers = 0.
- All outputs are registered; no combinational path from any input to any output.
- Prescaler: counts 0..DIV-1 while state != IDLE; `tick` is high in the cycle the count equals DIV-1, then the count returns to 0. With DIV=1, `tick` is high every cycle.
- Tick counter: width `$clog2(max(BLANK_TICKS,SHOW_TICKS)+1)`; cleared on every state change.
- States: IDLE, BLANK, SHOW.
  - IDLE: `en`=0, `sel`=0, prescaler and tick counter held at 0. If `run`=1, go to BLANK next cycle and load the shadow registers from `digits`/`digit_mask`.
  - BLANK: `en`=0. After BLANK_TICKS ticks, go to SHOW.
  - SHOW: `en` = shadow_mask[`sel`]. After SHOW_TICKS ticks, `sel` <= `sel`+1 (wraps 7->0) and go to BLANK.
- Frame wrap (SHOW->BLANK with `sel`=7):
  - `sel`=0 and `frame_done`=1 for exactly that one cycle.
  - The shadow registers reload from `digits`/`digit_mask` in the same cycle.
- Input changes mid-frame are ignored until the next frame wrap.
- `digit` = shadow_digits[4*`sel` +: 4]; updates in the same cycle as `sel`, and holds its value during BLANK.
- Timing per digit = (BLANK_TICKS+SHOW_TICKS)*DIV cycles; frame = 8x that.
- `run` deasserted in any state: next cycle state=IDLE, `en`=0, `sel`=0, `frame_done`=0, counters cleared. Re-asserting `run` always restarts at digit 0.
- `run` falling in the same cycle as a frame wrap: IDLE wins and no `frame_done` pulse is issued.
- `en` never rises in the same cycle `sel` changes; there is always at least DIV cycles of blanking between digits.

Optional Feature:
- Macro: DIG_SCAN_LZ_SUPPRESS_EN.
- Defined: leading-zero suppression, computed at each shadow load.
  - Scanning from digit 7 downward, every digit whose value is 0 has its effective mask bit cleared until the first nonzero digit is found.
  - Digit 0 is never suppressed.
  - Suppressed digits still occupy their BLANK/SHOW time slots, with `en`=0.
- Undefined: the effective mask equals `digit_mask` unchanged.

Decomposition:
- Package `dig_scan_pkg`:
  - state enum `scan_state_t` {IDLE, BLANK, SHOW}.
  - Constants `NUM_DIGITS`=8, `SEL_W`=3, `DIGIT_W`=4.
- Sub-module `tick_gen`:
  - Parameterised prescaler with ports clk, rst, clr, tick; `clr` is driven high in IDLE.
- The FSM, counters and shadow registers live in `dig_scan_ctrl`.

Test Plan:
Common settings: DIV=4, BLANK_TICKS=1, SHOW_TICKS=2 (digit slot 12 cycles, frame 96 cycles); `dut` feeds a `dec3to8` instance.
1. Reset/idle: hold `rst`=1, then `run`=0 for 20 cycles -> `sel`=0, `en`=0, `digit`=0, `frame_done`=0 throughout.
2. Full frame: `digits`=32'h7654_3210, `digit_mask`=8'hFF, `run`=1.
   - `sel` steps 0..7; each digit has 4 cycles of `en`=0 then 8 cycles of `en`=1.
   - `digit` equals `sel` in each slot.
   - `frame_done` pulses once, 96 cycles after the first BLANK entry; decoder output is one-hot 8'b0000_0001 << `sel` while `en`=1.
3. Coherence: change `digits` to 32'hFFFF_FFFF during digit 3 -> digits 4..7 still show 4..7; the next frame shows F on every digit.
4. Mask: `digit_mask`=8'b1010_0101 -> `en` high only in the slots for digits 0, 2, 5 and 7; slot timing unchanged.
5. Stop and async reset:
   - Drop `run` during SHOW of digit 5 -> next cycle `en`=0, `sel`=0; re-raising `run` restarts at digit 0.
   - Pulse `rst` mid-SHOW between clock edges -> `en` falls before the next edge.
6. With DIG_SCAN_LZ_SUPPRESS_EN defined: `digits`=32'h0001_0200, mask 8'hFF -> `en` is suppressed for digits 7..5 only; digits 4..0 are shown, including the zeros at digits 1 and 0.
